free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 105 ++++++++++
 tb/tb_free_list.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  free_list : circular physical-tag free list, 2-wide allocate / 2-wide free
//  Rev 1.0
// ============================================================================
module free_list #(
   parameter int FL_DEPTH    = 64,
   parameter int FL_FIRST_PR = 32
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [1:0]                        id_dispatch_num,
   input  logic                              id_valid_inst0,
   input  logic                              id_valid_inst1,
   input  logic [1:0]                        rob_retire_num,
   input  logic [6:0]                        rob_retire_told0,
   input  logic [6:0]                        rob_retire_told1,
   input  logic                              rob_recover,
   output logic [6:0]                        fl_pr0,
   output logic [6:0]                        fl_pr1,
   output logic [1:0]                        fl_free_num,
   output logic [$clog2(FL_DEPTH):0]         fl_count,
   output logic                              fl_overflow
);

   localparam int c_ptr_w = $clog2(FL_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FL_DEPTH);

   logic [6:0]         r_entry [FL_DEPTH];
   logic [c_ptr_w-1:0] r_head;
   logic [c_ptr_w-1:0] r_tail;
   logic [c_ptr_w-1:0] r_rt_head;
   logic [c_cnt_w-1:0] r_count;
   logic               r_overflow;

   logic [1:0]         w_disp;
   logic [1:0]         w_ret;
   logic               w_pop0;
   logic               w_pop1;
   logic [1:0]         w_npop;
   logic [c_cnt_w-1:0] w_space;
   logic               w_ovf;
   logic [1:0]         w_npush;
   logic [c_ptr_w-1:0] w_head1;
   logic [c_ptr_w-1:0] w_tail1;
   logic [c_ptr_w-1:0] w_rt_next;

   // Encoding 3 is illegal on both request buses and behaves as idle.
   assign w_disp = (id_dispatch_num == 2'd3) ? 2'd0 : id_dispatch_num;
   assign w_ret  = (rob_retire_num  == 2'd3) ? 2'd0 : rob_retire_num;

   assign w_pop0 = (w_disp != 2'd0) && id_valid_inst0 && (r_count != '0);
   assign w_pop1 = (w_disp == 2'd2) && id_valid_inst1 &&
                   (r_count >= (c_cnt_w'(1) + c_cnt_w'(w_pop0)));
   assign w_npop = rob_recover ? 2'd0 : (2'(w_pop0) + 2'(w_pop1));

   // Room left this cycle counts the slots freed by same-cycle pops.
   assign w_space   = c_depth - r_count + c_cnt_w'(w_npop);
   assign w_ovf     = c_cnt_w'(w_ret) > w_space;
   assign w_npush   = w_ovf ? w_space[1:0] : w_ret;

   assign w_head1   = r_head + c_ptr_w'(1);
   assign w_tail1   = r_tail + c_ptr_w'(1);
   assign w_rt_next = r_rt_head + c_ptr_w'(w_npush);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            r_entry[i] <= 7'(FL_FIRST_PR + i);
         end
         r_head     <= '0;
         r_tail     <= '0;
         r_rt_head  <= '0;
         r_count    <= c_depth;
         r_overflow <= 1'b0;
      end else begin
         if (w_npush != 2'd0) begin
            r_entry[r_tail] <= rob_retire_told0;
         end
         if (w_npush == 2'd2) begin
            r_entry[w_tail1] <= rob_retire_told1;
         end
         r_tail     <= r_tail + c_ptr_w'(w_npush);
         r_rt_head  <= w_rt_next;
         r_overflow <= r_overflow | w_ovf;
         if (rob_recover) begin
            r_head  <= w_rt_next;
            r_count <= c_depth;
         end else begin
            r_head  <= r_head + c_ptr_w'(w_npop);
            r_count <= r_count - c_cnt_w'(w_npop) + c_cnt_w'(w_npush);
         end
      end
   end

   // A lone slot-1 allocation takes the tag at head, so slot 1 follows valid0.
   assign fl_pr0      = r_entry[r_head];
   assign fl_pr1      = id_valid_inst0 ? r_entry[w_head1] : r_entry[r_head];
   assign fl_free_num = (r_count >= c_cnt_w'(2)) ? 2'd2 : r_count[1:0];
   assign fl_count    = r_count;
   assign fl_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// Directed self-checking bench for free_list.
module tb_free_list;

   logic       clock;
   logic       reset;
   logic [1:0] id_dispatch_num;
   logic       id_valid_inst0;
   logic       id_valid_inst1;
   logic [1:0] rob_retire_num;
   logic [6:0] rob_retire_told0;
   logic [6:0] rob_retire_told1;
   logic       rob_recover;
   logic [6:0] fl_pr0;
   logic [6:0] fl_pr1;
   logic [1:0] fl_free_num;
   logic [6:0] fl_count;
   logic       fl_overflow;

   int n_chk  = 0;
   int n_fail = 0;

   free_list #(.FL_DEPTH(64), .FL_FIRST_PR(32)) dut (
      .clock           (clock),
      .reset           (reset),
      .id_dispatch_num (id_dispatch_num),
      .id_valid_inst0  (id_valid_inst0),
      .id_valid_inst1  (id_valid_inst1),
      .rob_retire_num  (rob_retire_num),
      .rob_retire_told0(rob_retire_told0),
      .rob_retire_told1(rob_retire_told1),
      .rob_recover     (rob_recover),
      .fl_pr0          (fl_pr0),
      .fl_pr1          (fl_pr1),
      .fl_free_num     (fl_free_num),
      .fl_count        (fl_count),
      .fl_overflow     (fl_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic idle();
      id_dispatch_num  = 2'd0;
      id_valid_inst0   = 1'b1;
      id_valid_inst1   = 1'b1;
      rob_retire_num   = 2'd0;
      rob_retire_told0 = 7'd0;
      rob_retire_told1 = 7'd0;
      rob_recover      = 1'b0;
   endtask

   task automatic do_reset();
      cyc();
      idle();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      cyc();
      #1;
      chk("rst_pr0",   fl_pr0,      32);
      chk("rst_pr1",   fl_pr1,      33);
      chk("rst_free",  fl_free_num, 2);
      chk("rst_count", fl_count,    64);
      chk("rst_ovf",   fl_overflow, 0);

      // double allocate from reset
      reset = 1'b1;
      cyc();
      id_dispatch_num = 2'd2;
      #1;
      chk("dbl_pr0", fl_pr0, 32);
      chk("dbl_pr1", fl_pr1, 33);
      cyc();
      idle();
      #1;
      chk("dbl_next_pr0",   fl_pr0,   34);
      chk("dbl_next_pr1",   fl_pr1,   35);
      chk("dbl_next_count", fl_count, 62);

      // slot-1-only allocate
      do_reset();
      cyc();
      id_dispatch_num = 2'd2;
      id_valid_inst0  = 1'b0;
      #1;
      chk("s1_pr1", fl_pr1, 32);
      cyc();
      idle();
      #1;
      chk("s1_next_pr0",   fl_pr0,   33);
      chk("s1_next_count", fl_count, 63);

      // drain to empty
      do_reset();
      for (int i = 0; i < 31; i++) begin
         cyc();
         id_dispatch_num = 2'd2;
      end
      cyc();
      #1;
      chk("drain_count2", fl_count,    2);
      chk("drain_free2",  fl_free_num, 2);
      chk("drain_pr0",    fl_pr0,      94);
      chk("drain_pr1",    fl_pr1,      95);
      cyc();
      #1;
      chk("empty_count", fl_count,    0);
      chk("empty_free",  fl_free_num, 0);
      chk("empty_pr0",   fl_pr0,      32);
      cyc();
      #1;
      chk("empty_hold_pr0",   fl_pr0,   32);
      chk("empty_hold_count", fl_count, 0);

      // retire into empty list while dispatch is requested
      rob_retire_num   = 2'd2;
      rob_retire_told0 = 7'd5;
      rob_retire_told1 = 7'd9;
      cyc();
      idle();
      #1;
      chk("refill_pr0",   fl_pr0,      5);
      chk("refill_pr1",   fl_pr1,      9);
      chk("refill_count", fl_count,    2);
      chk("refill_free",  fl_free_num, 2);

      // recovery with same-cycle retire
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc();
         id_dispatch_num = 2'd2;
      end
      cyc();
      #1;
      chk("pop10_count", fl_count, 54);
      chk("pop10_pr0",   fl_pr0,   42);
      rob_retire_num   = 2'd2;
      rob_retire_told0 = 7'd3;
      rob_retire_told1 = 7'd4;
      rob_recover      = 1'b1;
      cyc();
      idle();
      #1;
      chk("recover_pr0",   fl_pr0,   34);
      chk("recover_pr1",   fl_pr1,   35);
      chk("recover_count", fl_count, 64);
      chk("recover_ovf",   fl_overflow, 0);

      // encoding 3 on both buses is idle
      id_dispatch_num  = 2'd3;
      rob_retire_num   = 2'd3;
      rob_retire_told0 = 7'd99;
      rob_retire_told1 = 7'd98;
      cyc();
      idle();
      #1;
      chk("enc3_count", fl_count,    64);
      chk("enc3_pr0",   fl_pr0,      34);
      chk("enc3_ovf",   fl_overflow, 0);

      // overflow, then asynchronous clear
      do_reset();
      cyc();
      rob_retire_num   = 2'd1;
      rob_retire_told0 = 7'd7;
      cyc();
      idle();
      #1;
      chk("ovf_flag",  fl_overflow, 1);
      chk("ovf_count", fl_count,    64);
      chk("ovf_pr0",   fl_pr0,      32);
      cyc();
      #1;
      chk("ovf_sticky", fl_overflow, 1);
      id_dispatch_num = 2'd2;
      cyc();
      #1;
      reset = 1'b0;
      #1;
      chk("async_ovf",   fl_overflow, 0);
      chk("async_count", fl_count,    64);
      chk("async_pr0",   fl_pr0,      32);
      reset = 1'b1;
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
